// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the fetch/data memory arbiter.
//   owner_t   : which requester owns an in-flight read (or none)
//   byte_en_t : 4-bit byte-enable vector
//   BE_WORD   : full-word byte enable used for instruction fetches
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_t;

    typedef logic [3:0] byte_en_t;

    localparam byte_en_t BE_WORD = 4'hF;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the arbiter:
//   fetch  : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   data   : d_req, d_we, d_be, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory : m_req, m_we, m_be, m_addr, m_wdata -> m_rdata
// Modports:
//   slave  : the arbiter's view (core requests in, memory commands out)
//   master : the surrounding system's view (core + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    // Fetch port
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    // Load/store port
    logic                  d_req;
    logic                  d_we;
    byte_en_t              d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    // Unified memory port
    logic                  m_req;
    logic                  m_we;
    byte_en_t              m_be;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_rdata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_tag_pipe.sv
// -----------------------------------------------------------------------------
// arb_tag_pipe
// LATENCY-deep shift register of owner tags. Each cycle the tag of the access
// issued to memory enters at stage 0; the tag leaving the last stage names
// the requester whose read data is on m_rdata this cycle.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low clear (all stages -> OWN_NONE)
//   tag_i  : owner of the access issued this cycle
//   tag_o  : owner of the read data returning this cycle
// -----------------------------------------------------------------------------
module arb_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic   clk,
    input  logic   resetn,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t pipe_q [LATENCY];

    // NOTE: every stage is cleared on reset, unlike a data RAM, because these
    // tags raise rvalid; stale tags would produce responses for discarded reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= OWN_NONE;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its neighbour, so the loop order does not matter.
            pipe_q[0] <= tag_i;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign tag_o = pipe_q[LATENCY-1];

endmodule : arb_tag_pipe

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported pipelined memory between instruction fetch and the
// load/store port. Data wins contention, except that after STARVE_LIMIT
// consecutive contested data grants fetch is forced through. Read responses
// are routed back by an owner tag travelling alongside the memory latency.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (fetch, data and memory buses)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);

    owner_t grant;
    owner_t tag_in;
    owner_t tag_out;

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Last command driven to memory; replayed on idle cycles so the memory
    // address/data lines do not toggle when nothing is issued.
    logic                  m_we_q,    m_we_d;
    byte_en_t              m_be_q,    m_be_d;
    logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;

    // -------------------------------------------------------------------------
    // Grant selection and starvation counter
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        grant        = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        // Grants are suppressed while reset is held so nothing reaches memory.
        if (resetn) begin
            if (bus.i_req && bus.d_req) begin
                if (starve_cnt_q < 4'(STARVE_LIMIT)) begin
                    grant        = OWN_DMEM;
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end else begin
                    grant = OWN_IMEM;
                end
            end else if (bus.i_req) begin
                grant = OWN_IMEM;
            end else if (bus.d_req) begin
                grant = OWN_DMEM;
            end
        end

        // Any fetch grant ends a starvation run, contested or not.
        if (grant == OWN_IMEM) begin
            starve_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Memory command mux
    // -------------------------------------------------------------------------
    always_comb begin
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        tag_in    = OWN_NONE;

        unique case (grant)
            OWN_IMEM: begin
                m_we_d   = 1'b0;
                m_be_d   = BE_WORD;
                m_addr_d = bus.i_addr;
                tag_in   = OWN_IMEM;
            end
            OWN_DMEM: begin
                m_we_d    = bus.d_we;
                m_be_d    = bus.d_be;
                m_addr_d  = bus.d_addr;
                m_wdata_d = bus.d_wdata;
                // Stores produce no response, so they travel as an empty slot.
                tag_in    = bus.d_we ? OWN_NONE : OWN_DMEM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
            m_we_q       <= 1'b0;
            m_be_q       <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            m_we_q       <= m_we_d;
            m_be_q       <= m_be_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign bus.i_gnt   = (grant == OWN_IMEM);
    assign bus.d_gnt   = (grant == OWN_DMEM);
    assign bus.m_req   = (grant != OWN_NONE);
    assign bus.m_we    = m_we_d;
    assign bus.m_be    = m_be_d;
    assign bus.m_addr  = m_addr_d;
    assign bus.m_wdata = m_wdata_d;

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    arb_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .resetn (resetn),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // Only one tag exits per cycle, so the two rvalids are exclusive.
    assign bus.i_rvalid = (tag_out == OWN_IMEM);
    assign bus.d_rvalid = (tag_out == OWN_DMEM);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Two instances share clock and reset:
//   u_dut1 : LATENCY=1, STARVE_LIMIT=3
//   u_dut3 : LATENCY=3, STARVE_LIMIT=3
// Each is attached to a small behavioural memory with the matching latency.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .LATENCY      (1),
        .STARVE_LIMIT (3)
    ) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .LATENCY      (3),
        .STARVE_LIMIT (3)
    ) u_dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus3.slave)
    );

    // -------------------------------------------------------------------------
    // Behavioural memories: word array indexed by addr[9:2], read pipeline of
    // LATENCY registers, byte-enabled writes.
    // -------------------------------------------------------------------------
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];

    always @(posedge clk) begin
        if (bus1.m_req && bus1.m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus1.m_be[b]) mem1[bus1.m_addr[9:2]][8*b +: 8] <= bus1.m_wdata[8*b +: 8];
            end
        end
        rd1 <= (bus1.m_req && !bus1.m_we) ? mem1[bus1.m_addr[9:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (bus3.m_req && bus3.m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus3.m_be[b]) mem3[bus3.m_addr[9:2]][8*b +: 8] <= bus3.m_wdata[8*b +: 8];
            end
        end
        rd3[0] <= (bus3.m_req && !bus3.m_we) ? mem3[bus3.m_addr[9:2]] : 32'h0;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign bus1.m_rdata = rd1;
    assign bus3.m_rdata = rd3[2];

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus1.i_req = 1'b0; bus1.i_addr = '0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_be = 4'h0;
        bus1.d_addr = '0;  bus1.d_wdata = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0;
        bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_be = 4'h0;
        bus3.d_addr = '0;  bus3.d_wdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_i_gnt1"},    32'(bus1.i_gnt),    32'd0);
        check({tag, "_d_gnt1"},    32'(bus1.d_gnt),    32'd0);
        check({tag, "_m_req1"},    32'(bus1.m_req),    32'd0);
        check({tag, "_i_rvalid1"}, 32'(bus1.i_rvalid), 32'd0);
        check({tag, "_d_rvalid1"}, 32'(bus1.d_rvalid), 32'd0);
        check({tag, "_m_req3"},    32'(bus3.m_req),    32'd0);
        check({tag, "_i_rvalid3"}, 32'(bus3.i_rvalid), 32'd0);
        check({tag, "_d_rvalid3"}, 32'(bus3.d_rvalid), 32'd0);
    endtask

    // Contention pattern with STARVE_LIMIT=3: 1 = data granted, 0 = fetch.
    logic [7:0] exp_dgnt;

    initial begin
        for (int w = 0; w < 256; w++) begin
            mem1[w] = 32'hCC00_0000 | 32'(w);
            mem3[w] = 32'hEE00_0000 | 32'(w);
        end
        mem1[32'h100 >> 2] = 32'hAAAA_0100;
        mem1[32'h104 >> 2] = 32'hBBBB_0104;
        mem1[32'h108 >> 2] = 32'hCCCC_0108;
        mem1[32'h020 >> 2] = 32'h1122_3344;
        mem3[32'h000 >> 2] = 32'h1111_0000;
        mem3[32'h040 >> 2] = 32'hD40D_0040;
        mem3[32'h004 >> 2] = 32'h1111_0004;

        // ---------------- Reset then idle ----------------
        resetn = 1'b0;
        idle_inputs();
        // A fetch request held during reset must still not be granted.
        bus1.i_req  = 1'b1;
        bus1.i_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            sample();
            check_quiet("rst");
            next_cycle();
        end
        bus1.i_req = 1'b0;
        resetn     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sample();
            check_quiet("idle");
            next_cycle();
        end

        // ---------------- Fetch only, LATENCY=1 ----------------
        bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
        sample();
        check("f0_gnt",    32'(bus1.i_gnt),    32'd1);
        check("f0_maddr",  bus1.m_addr,        32'h100);
        check("f0_mwe",    32'(bus1.m_we),     32'd0);
        check("f0_mbe",    32'(bus1.m_be),     32'hF);
        check("f0_rvalid", 32'(bus1.i_rvalid), 32'd0);
        next_cycle();
        bus1.i_addr = 32'h104;
        sample();
        check("f1_gnt",    32'(bus1.i_gnt),    32'd1);
        check("f1_rvalid", 32'(bus1.i_rvalid), 32'd1);
        check("f1_rdata",  bus1.i_rdata,       32'hAAAA_0100);
        check("f1_drv",    32'(bus1.d_rvalid), 32'd0);
        next_cycle();
        bus1.i_addr = 32'h108;
        sample();
        check("f2_gnt",    32'(bus1.i_gnt),    32'd1);
        check("f2_rvalid", 32'(bus1.i_rvalid), 32'd1);
        check("f2_rdata",  bus1.i_rdata,       32'hBBBB_0104);
        next_cycle();
        bus1.i_req = 1'b0; bus1.i_addr = 32'h0;
        sample();
        check("f3_gnt",    32'(bus1.i_gnt),    32'd0);
        check("f3_mreq",   32'(bus1.m_req),    32'd0);
        check("f3_hold",   bus1.m_addr,        32'h108);
        check("f3_rvalid", 32'(bus1.i_rvalid), 32'd1);
        check("f3_rdata",  bus1.i_rdata,       32'hCCCC_0108);
        check("f3_drv",    32'(bus1.d_rvalid), 32'd0);
        next_cycle();
        sample();
        check("f4_rvalid", 32'(bus1.i_rvalid), 32'd0);
        next_cycle();

        // ---------------- Contention, STARVE_LIMIT=3 ----------------
        exp_dgnt = 8'b0111_0111; // bit c = cycle c: D D D I D D D I
        bus1.i_req = 1'b1; bus1.i_addr = 32'h300;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h200;
        for (int c = 0; c < 8; c++) begin
            sample();
            check($sformatf("con%0d_dgnt", c),  32'(bus1.d_gnt), 32'(exp_dgnt[c]));
            check($sformatf("con%0d_ignt", c),  32'(bus1.i_gnt), 32'(!exp_dgnt[c]));
            check($sformatf("con%0d_maddr", c), bus1.m_addr, exp_dgnt[c] ? 32'h200 : 32'h300);
            check($sformatf("con%0d_excl", c),
                  32'(bus1.i_rvalid & bus1.d_rvalid), 32'd0);
            next_cycle();
        end
        idle_inputs();
        sample();
        // Last contested cycle granted fetch, so its response returns now.
        check("con_tail_irv", 32'(bus1.i_rvalid), 32'd1);
        check("con_tail_drv", 32'(bus1.d_rvalid), 32'd0);
        next_cycle();

        // ---------------- Store then load, LATENCY=1 ----------------
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_be = 4'h3;
        bus1.d_addr = 32'h20; bus1.d_wdata = 32'hDEAD_BEEF;
        sample();
        check("st_gnt",   32'(bus1.d_gnt),  32'd1);
        check("st_mwe",   32'(bus1.m_we),   32'd1);
        check("st_mbe",   32'(bus1.m_be),   32'h3);
        check("st_wdata", bus1.m_wdata,     32'hDEAD_BEEF);
        next_cycle();
        bus1.d_we = 1'b0; bus1.d_be = 4'hF;
        sample();
        check("ld_gnt",     32'(bus1.d_gnt),    32'd1);
        check("st_no_rv",   32'(bus1.d_rvalid), 32'd0);
        next_cycle();
        idle_inputs();
        sample();
        check("ld_rvalid",  32'(bus1.d_rvalid), 32'd1);
        check("ld_rdata",   bus1.d_rdata,       32'h1122_BEEF);
        check("ld_irv",     32'(bus1.i_rvalid), 32'd0);
        next_cycle();
        sample();
        check("ld_done",    32'(bus1.d_rvalid), 32'd0);
        next_cycle();

        // ---------------- Interleaved responses, LATENCY=3 ----------------
        bus3.i_req = 1'b1; bus3.i_addr = 32'h0;
        sample();
        check("il0_ignt", 32'(bus3.i_gnt), 32'd1);
        next_cycle();
        bus3.i_req = 1'b0;
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
        sample();
        check("il1_dgnt", 32'(bus3.d_gnt),    32'd1);
        check("il1_irv",  32'(bus3.i_rvalid), 32'd0);
        next_cycle();
        bus3.d_req = 1'b0;
        bus3.i_req = 1'b1; bus3.i_addr = 32'h4;
        sample();
        check("il2_ignt", 32'(bus3.i_gnt),    32'd1);
        check("il2_irv",  32'(bus3.i_rvalid), 32'd0);
        check("il2_drv",  32'(bus3.d_rvalid), 32'd0);
        next_cycle();
        idle_inputs();
        sample();
        check("il3_irv",   32'(bus3.i_rvalid), 32'd1);
        check("il3_drv",   32'(bus3.d_rvalid), 32'd0);
        check("il3_rdata", bus3.i_rdata,       32'h1111_0000);
        next_cycle();
        sample();
        check("il4_irv",   32'(bus3.i_rvalid), 32'd0);
        check("il4_drv",   32'(bus3.d_rvalid), 32'd1);
        check("il4_rdata", bus3.d_rdata,       32'hD40D_0040);
        next_cycle();
        sample();
        check("il5_irv",   32'(bus3.i_rvalid), 32'd1);
        check("il5_drv",   32'(bus3.d_rvalid), 32'd0);
        check("il5_rdata", bus3.i_rdata,       32'h1111_0004);
        next_cycle();
        sample();
        check("il6_irv",   32'(bus3.i_rvalid), 32'd0);
        next_cycle();

        // ---------------- Reset mid-flight, LATENCY=3 ----------------
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h80;
        sample();
        check("rf0_dgnt", 32'(bus3.d_gnt), 32'd1);
        next_cycle();
        bus3.d_addr = 32'h84;
        sample();
        check("rf1_dgnt", 32'(bus3.d_gnt),    32'd1);
        check("rf1_drv",  32'(bus3.d_rvalid), 32'd0);
        next_cycle();
        idle_inputs();
        resetn = 1'b0;
        sample();
        check("rf2_drv", 32'(bus3.d_rvalid), 32'd0);
        next_cycle();
        resetn = 1'b1;
        for (int c = 3; c < 7; c++) begin
            sample();
            check($sformatf("rf%0d_drv", c), 32'(bus3.d_rvalid), 32'd0);
            check($sformatf("rf%0d_irv", c), 32'(bus3.i_rvalid), 32'd0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
